// File: rtl/fetch_seq_if.sv
// Handshake and PC-control bundle between the top-level control, the PC register and fetch_seq.
// The master modport is the top-level/datapath side and the slave modport is the sequencer.
interface fetch_seq_if #(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned CNT_W = 32
);
  logic             Start;
  logic [1:0]       Prog_sel;
  logic             Halt_instr;
  logic             Stall_req;
  logic             Branch_req;
  logic             Flag_in;
  logic [PC_W-1:0]  Target_in;
  logic             Ack;
  logic             PC_load;
  logic [PC_W-1:0]  PC_val;
  logic             PC_hold;
  logic             Busy;
  logic             Done;
  logic             Err;
  logic [CNT_W-1:0] Cycle_cnt;

  modport master (
    output Start, Prog_sel, Halt_instr, Stall_req, Branch_req, Flag_in, Target_in, Ack,
    input  PC_load, PC_val, PC_hold, Busy, Done, Err, Cycle_cnt
  );

  modport slave (
    input  Start, Prog_sel, Halt_instr, Stall_req, Branch_req, Flag_in, Target_in, Ack,
    output PC_load, PC_val, PC_hold, Busy, Done, Err, Cycle_cnt
  );
endinterface

// File: rtl/fetch_seq.sv
// Instruction-fetch PC sequencer: program load, run, stall freeze, branch forwarding, halt/Done/Ack.
// Optional watchdog timeout enabled by defining FETCH_SEQ_WATCHDOG_EN.
module fetch_seq #(
  parameter int unsigned    PC_W      = 16,
  parameter logic [PC_W-1:0] BASE0    = 16'h0000,
  parameter logic [PC_W-1:0] BASE1    = 16'h0100,
  parameter logic [PC_W-1:0] BASE2    = 16'h0200,
  parameter int unsigned    STALL_CYC = 2,
  parameter int unsigned    CNT_W     = 32,
  parameter int unsigned    MAX_CYC   = 100000
) (
  input logic       CLK,
  input logic       Reset_n,
  fetch_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STALL,
    S_DONE
  } state_t;

  // The STALL state covers the freeze cycles after the request cycle, i.e. STALL_CYC-1 of them.
  localparam int unsigned SC_W = (STALL_CYC > 2) ? $clog2(STALL_CYC) : 1;
  localparam logic [SC_W-1:0] STALL_INIT = SC_W'(STALL_CYC - 1);

  state_t           state_q, state_d;
  logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [PC_W-1:0]  pc_val_q, pc_val_d;
  logic             pc_load_q, pc_load_d;
  logic             pc_hold_q, pc_hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic timeout;
  logic in_run;
  logic halt_now;
  logic stall_now;
  logic branch_now;
  logic load_out;

`ifdef FETCH_SEQ_WATCHDOG_EN
  assign timeout = ((state_q == S_RUN) || (state_q == S_STALL)) &&
                   (cycle_cnt_q == CNT_W'(MAX_CYC));
`else
  logic unused_max_cyc;
  assign unused_max_cyc = ^MAX_CYC;
  assign timeout        = 1'b0;
`endif

  // RUN-cycle priority: timeout, halt, stall, taken branch.
  assign in_run     = (state_q == S_RUN) && !timeout;
  assign halt_now   = in_run && bus.Halt_instr;
  assign stall_now  = in_run && !bus.Halt_instr && bus.Stall_req;
  assign branch_now = in_run && !bus.Halt_instr && !bus.Stall_req &&
                      bus.Branch_req && bus.Flag_in;

  assign cnt_inc = (cycle_cnt_q == {CNT_W{1'b1}}) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    pc_val_d    = pc_val_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          if (bus.Prog_sel == 2'd3) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d     = S_LOAD;
            cycle_cnt_d = '0;
            case (bus.Prog_sel)
              2'd0:    pc_val_d = BASE0;
              2'd1:    pc_val_d = BASE1;
              default: pc_val_d = BASE2;
            endcase
          end
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cycle_cnt_d = cnt_inc;
          if (halt_now) begin
            state_d = S_DONE;
          end else if (stall_now && (STALL_CYC > 1)) begin
            state_d     = S_STALL;
            stall_cnt_d = STALL_INIT;
          end
        end
      end
      S_STALL: begin
        if (timeout) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cycle_cnt_d = cnt_inc;
          stall_cnt_d = stall_cnt_q - SC_W'(1);
          if (stall_cnt_q == SC_W'(1)) begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        if (bus.Ack) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_STALL);
    done_d    = (state_d == S_DONE);
    pc_load_d = (state_d == S_LOAD);
    pc_hold_d = (state_d == S_IDLE) || (state_d == S_STALL) || (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      stall_cnt_q <= '0;
      cycle_cnt_q <= '0;
      pc_val_q    <= '0;
      pc_load_q   <= 1'b0;
      pc_hold_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      pc_val_q    <= pc_val_d;
      pc_load_q   <= pc_load_d;
      pc_hold_q   <= pc_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Stall and taken-branch controls bypass the registers so they act on this cycle's edge.
  assign load_out      = pc_load_q || branch_now;
  assign bus.PC_load   = load_out;
  assign bus.PC_val    = branch_now ? bus.Target_in : pc_val_q;
  assign bus.PC_hold   = (pc_hold_q || stall_now) && !load_out;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Err       = err_q;
  assign bus.Cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: directed scenarios plus random traffic checked against a
// cycle-level behavioural model of the sequencer's externally visible rules.
module tb_fetch_seq;

  localparam int unsigned PC_W      = 16;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned STALL_CYC = 2;
  localparam int unsigned MAX_CYC   = 10;
`ifdef FETCH_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef struct packed {
    logic        rst_n;
    logic        start;
    logic [1:0]  sel;
    logic        halt;
    logic        stall;
    logic        branch;
    logic        flag;
    logic [15:0] target;
    logic        ack;
  } stim_t;

  typedef struct packed {
    logic        load;
    logic        hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] pc_val;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_seq_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  fetch_seq #(
    .PC_W(PC_W), .BASE0(16'h0000), .BASE1(16'h0100), .BASE2(16'h0200),
    .STALL_CYC(STALL_CYC), .CNT_W(CNT_W), .MAX_CYC(MAX_CYC)
  ) dut (
    .CLK(clk),
    .Reset_n(rst_n),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: what phase of a run we are in, described by flags and remaining freeze cycles.
  bit          m_loading = 0;
  bit          m_running = 0;
  bit          m_done    = 0;
  bit          m_err     = 0;
  int          m_freeze  = 0;
  logic [15:0] m_pc_val  = '0;
  longint      m_cnt     = 0;

  function automatic longint sat_inc(input longint v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic model_step(input stim_t s, output exp_t e);
    bit tmo;
    e = '0;
    e.pc_val = m_pc_val;
    e.cnt    = m_cnt[31:0];
    if (!s.rst_n) begin
      m_loading = 0; m_running = 0; m_done = 0; m_err = 0; m_freeze = 0;
      m_pc_val = '0; m_cnt = 0;
      e.hold = 1'b1; e.pc_val = '0; e.cnt = '0;
      return;
    end
    tmo = WD_EN && m_running && (m_cnt == longint'(MAX_CYC));
    if (m_done) begin
      e.done = 1'b1; e.err = m_err; e.hold = 1'b1;
      if (s.ack) begin m_done = 0; m_err = 0; end
    end else if (m_loading) begin
      e.load = 1'b1; e.busy = 1'b1;
      m_loading = 0; m_running = 1;
    end else if (m_running) begin
      e.busy = 1'b1;
      if (m_freeze > 0) begin
        e.hold = 1'b1;
        if (tmo) begin m_running = 0; m_done = 1; m_err = 1; m_freeze = 0; end
        else begin m_cnt = sat_inc(m_cnt); m_freeze--; end
      end else if (tmo) begin
        m_running = 0; m_done = 1; m_err = 1;
      end else begin
        m_cnt = sat_inc(m_cnt);
        if (s.halt) begin
          m_running = 0; m_done = 1;
        end else if (s.stall) begin
          e.hold = 1'b1;
          m_freeze = int'(STALL_CYC) - 1;
        end else if (s.branch && s.flag) begin
          e.load = 1'b1; e.pc_val = s.target;
        end
      end
    end else begin
      e.hold = 1'b1;
      if (s.start) begin
        if (s.sel == 2'd3) begin
          m_done = 1; m_err = 1;
        end else begin
          m_loading = 1; m_cnt = 0;
          m_pc_val = 16'h0100 * 16'(s.sel);
        end
      end
    end
  endtask

  task automatic apply_stimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = s.rst_n;
    bus.Start      = s.start;
    bus.Prog_sel   = s.sel;
    bus.Halt_instr = s.halt;
    bus.Stall_req  = s.stall;
    bus.Branch_req = s.branch;
    bus.Flag_in    = s.flag;
    bus.Target_in  = s.target;
    bus.Ack        = s.ack;
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    logic [4:0] act_ctrl, exp_ctrl;
    act_ctrl = {bus.PC_load, bus.PC_hold, bus.Busy, bus.Done, bus.Err};
    exp_ctrl = {e.load, e.hold, e.busy, e.done, e.err};
    checks++;
    if (act_ctrl !== exp_ctrl) begin
      errors++;
      $display("[TB] FAIL ctrl{load,hold,busy,done,err} at %0t: got %b expected %b",
               $time, act_ctrl, exp_ctrl);
    end
    checks++;
    if (bus.PC_val !== e.pc_val) begin
      errors++;
      $display("[TB] FAIL pc_val at %0t: got %h expected %h", $time, bus.PC_val, e.pc_val);
    end
    checks++;
    if (bus.Cycle_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL cycle_cnt at %0t: got %0d expected %0d", $time, bus.Cycle_cnt, e.cnt);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output(mon_e);
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(nop());
  endtask

  initial begin
    stim_t s;
    bus.Start = 1'b0; bus.Prog_sel = '0; bus.Halt_instr = 1'b0; bus.Stall_req = 1'b0;
    bus.Branch_req = 1'b0; bus.Flag_in = 1'b0; bus.Target_in = '0; bus.Ack = 1'b0;

    s = nop(); s.rst_n = 1'b0;
    apply_stimulus(s); apply_stimulus(s);
    idle_cycles(1);

    // Basic run from program 1, five RUN cycles then halt, then acknowledge.
    s = nop(); s.start = 1'b1; s.sel = 2'd1; apply_stimulus(s);
    idle_cycles(6);
    s = nop(); s.halt = 1'b1; apply_stimulus(s);
    idle_cycles(1);
    s = nop(); s.ack = 1'b1; apply_stimulus(s);
    idle_cycles(1);

    // Taken and not-taken branches.
    s = nop(); s.start = 1'b1; s.sel = 2'd0; apply_stimulus(s);
    idle_cycles(2);
    s = nop(); s.branch = 1'b1; s.flag = 1'b1; s.target = 16'h0042; apply_stimulus(s);
    s.flag = 1'b0; apply_stimulus(s);
    s = nop(); s.halt = 1'b1; apply_stimulus(s);
    s = nop(); s.ack = 1'b1; apply_stimulus(s);
    idle_cycles(1);

    // Stall with a branch inside it, then halt+stall together with Ack already high.
    s = nop(); s.start = 1'b1; s.sel = 2'd2; apply_stimulus(s);
    idle_cycles(2);
    s = nop(); s.stall = 1'b1; apply_stimulus(s);
    s = nop(); s.branch = 1'b1; s.flag = 1'b1; s.target = 16'h1234; s.halt = 1'b1; apply_stimulus(s);
    idle_cycles(2);
    s = nop(); s.halt = 1'b1; s.stall = 1'b1; s.ack = 1'b1; apply_stimulus(s);
    s = nop(); s.ack = 1'b1; apply_stimulus(s);
    idle_cycles(1);

    // Invalid program select, Start ignored in DONE.
    s = nop(); s.start = 1'b1; s.sel = 2'd3; apply_stimulus(s);
    idle_cycles(1);
    s = nop(); s.start = 1'b1; s.sel = 2'd1; apply_stimulus(s);
    s = nop(); s.ack = 1'b1; apply_stimulus(s);
    idle_cycles(1);

    // Reset in the middle of a stall, then restart program 0.
    s = nop(); s.start = 1'b1; s.sel = 2'd1; apply_stimulus(s);
    idle_cycles(2);
    s = nop(); s.stall = 1'b1; apply_stimulus(s);
    s = nop(); s.rst_n = 1'b0; apply_stimulus(s);
    idle_cycles(1);
    s = nop(); s.start = 1'b1; s.sel = 2'd0; apply_stimulus(s);
    idle_cycles(3);
    s = nop(); s.halt = 1'b1; apply_stimulus(s);
    s = nop(); s.ack = 1'b1; apply_stimulus(s);

    // Long run without halt: times out with the watchdog, otherwise keeps running.
    s = nop(); s.start = 1'b1; s.sel = 2'd2; apply_stimulus(s);
    idle_cycles(50);
    s = nop(); s.halt = 1'b1; apply_stimulus(s);
    idle_cycles(1);
    s = nop(); s.ack = 1'b1; apply_stimulus(s);
    idle_cycles(1);

    for (int i = 0; i < 600; i++) begin
      s        = nop();
      s.rst_n  = ($urandom_range(0, 199) != 0);
      s.start  = ($urandom_range(0, 5) == 0);
      s.sel    = 2'($urandom_range(0, 3));
      s.halt   = ($urandom_range(0, 11) == 0);
      s.stall  = ($urandom_range(0, 5) == 0);
      s.branch = ($urandom_range(0, 2) == 0);
      s.flag   = 1'($urandom_range(0, 1));
      s.target = 16'($urandom);
      s.ack    = ($urandom_range(0, 2) == 0);
      apply_stimulus(s);
    end
    idle_cycles(2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
